// File: rtl/seven_segment_pkg.sv
// rtl/seven_segment_pkg.sv - glyph constants and segment-to-nibble decode for the display sniffer
// Contents: SEG_BIT_A..SEG_BIT_G  bit positions of segments a..g on the 7-bit segment bus
//           SEG_0..SEG_F          active-high glyph patterns for hex digits 0..F
//           seg_to_bin()          pattern -> {err, nibble}; unknown patterns give {1, 0}
package seven_segment_pkg;

    localparam int SEG_BIT_A = 0;
    localparam int SEG_BIT_B = 1;
    localparam int SEG_BIT_C = 2;
    localparam int SEG_BIT_D = 3;
    localparam int SEG_BIT_E = 4;
    localparam int SEG_BIT_F = 5;
    localparam int SEG_BIT_G = 6;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    // Blank (00) and any partial/garbled pattern decode as nibble 0 with err set.
    function automatic logic [4:0] seg_to_bin(input logic [6:0] pattern);
        logic [4:0] r;
        case (pattern)
            SEG_0:   r = 5'h00;
            SEG_1:   r = 5'h01;
            SEG_2:   r = 5'h02;
            SEG_3:   r = 5'h03;
            SEG_4:   r = 5'h04;
            SEG_5:   r = 5'h05;
            SEG_6:   r = 5'h06;
            SEG_7:   r = 5'h07;
            SEG_8:   r = 5'h08;
            SEG_9:   r = 5'h09;
            SEG_A:   r = 5'h0A;
            SEG_B:   r = 5'h0B;
            SEG_C:   r = 5'h0C;
            SEG_D:   r = 5'h0D;
            SEG_E:   r = 5'h0E;
            SEG_F:   r = 5'h0F;
            default: r = 5'h10;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seven_segment_to_bin.sv
// rtl/seven_segment_to_bin.sv - combinational seven-segment glyph to hex nibble decoder
// Ports: seg    in  [6:0]  segment pattern, bit0 = a .. bit6 = g
//        nibble out [3:0]  decoded hex value (0 when err)
//        err    out        pattern is not a legal hex glyph
module seven_segment_to_bin
    import seven_segment_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       err
);

    logic [4:0] decoded;

    assign decoded       = seg_to_bin(seg);
    assign {err, nibble} = decoded;

endmodule

// File: rtl/seven_segment_sniffer.sv
// rtl/seven_segment_sniffer.sv - passive multiplexed seven-segment bus receiver and frame assembler
// Ports: clk          in             system clock
//        rst_n        in             asynchronous active-low reset
//        seg          in  [6:0]      segment lines (async), bit0 = a .. bit6 = g
//        an           in  [DIGITS-1:0] one-hot digit enables (async)
//        value        out [4*DIGITS-1:0] last committed frame, digit i at [4i+3:4i]
//        digit_err    out [DIGITS-1:0] per-digit illegal-glyph flags of last frame
//        frame_valid  out            one-cycle pulse when value/digit_err update
//        led_ind      out [3:0]      nibble of the most recently accepted digit
module seven_segment_sniffer
    import seven_segment_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 8
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg,
    input  logic [DIGITS-1:0]     an,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     digit_err,
    output logic                  frame_valid,
    output logic [3:0]            led_ind
);

    localparam int               W        = DIGITS + 7;
    localparam logic [7:0]       CNT_MAX  = 8'(STABLE_CYCLES);
    localparam logic [7:0]       CNT_ACC  = 8'(STABLE_CYCLES - 1);
    localparam logic [DIGITS-1:0] ALL_SEEN = '1;

    logic [W-1:0]          sync1;
    logic [W-1:0]          s;
    logic [W-1:0]          p;
    logic [7:0]            cnt;
    logic [6:0]            seg_s;
    logic [DIGITS-1:0]     an_s;
    logic [3:0]            nibble;
    logic                  err;
    logic                  stable;
    logic                  accept;
    logic                  onehot;
    logic [DIGITS-1:0]     take;
    logic                  frame_full;
    logic [4*DIGITS-1:0]   shadow;
    logic [DIGITS-1:0]     err_shadow;
    logic [DIGITS-1:0]     seen;

    assign seg_s  = s[6:0];
    assign an_s   = s[W-1:7];
    assign stable = (s == p);

    // Fires on the single cycle where the window first reaches full length;
    // the counter then saturates so a long hold never re-accepts.
    assign accept = stable && (cnt == CNT_ACC);

    // x & (x-1) clears the lowest set bit, so zero remainder means at most one bit set.
    assign onehot = (an_s != '0) && ((an_s & (an_s - DIGITS'(1))) == '0);

    // With a guaranteed one-hot enable, the enable itself is the per-digit write strobe.
    assign take       = (accept && onehot) ? an_s : '0;
    assign frame_full = (seen == ALL_SEEN);

    seven_segment_to_bin u_dec (
        .seg    (seg_s),
        .nibble (nibble),
        .err    (err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            s     <= '0;
            p     <= '0;
        end else begin
            sync1 <= {an, seg};
            s     <= sync1;
            p     <= s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!stable) begin
            cnt <= '0;
        end else if (cnt < CNT_MAX) begin
            cnt <= cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow     <= '0;
            err_shadow <= '0;
            led_ind    <= '0;
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                if (take[i]) begin
                    shadow[4*i +: 4] <= nibble;
                    err_shadow[i]    <= err;
                end
            end
            if (take != '0) begin
                led_ind <= nibble;
            end
        end
    end

    // Commit the cycle after seen fills; an accept landing in the commit cycle
    // starts the next frame rather than being lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen        <= '0;
            value       <= '0;
            digit_err   <= '0;
            frame_valid <= 1'b0;
        end else begin
            seen        <= (frame_full ? '0 : seen) | take;
            frame_valid <= frame_full;
            if (frame_full) begin
                value     <= shadow;
                digit_err <= err_shadow;
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_sniffer.sv
// tb/tb_seven_segment_sniffer.sv - directed self-checking bench for seven_segment_sniffer
module tb_seven_segment_sniffer;

    logic        clk;
    logic        rst_n;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] value;
    logic [3:0]  digit_err;
    logic        frame_valid;
    logic [3:0]  led_ind;

    int checks = 0;
    int errors = 0;
    int fv_count = 0;
    bit watch = 0;
    bit saw_one = 0;
    int lat;
    bit got;

    seven_segment_sniffer #(.DIGITS(4), .STABLE_CYCLES(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg         (seg),
        .an          (an),
        .value       (value),
        .digit_err   (digit_err),
        .frame_valid (frame_valid),
        .led_ind     (led_ind)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && frame_valid) fv_count++;
        if (watch && led_ind == 4'h1) saw_one = 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic show(input logic [3:0] a, input logic [6:0] sg, input int n);
        an  = a;
        seg = sg;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 0;
        an    = 4'b0000;
        seg   = 7'h00;
        repeat (3) @(negedge clk);
        chk("reset_value", value, 16'h0000);
        chk("reset_err", digit_err, 4'h0);
        chk("reset_fv", frame_valid, 1'b0);
        chk("reset_led", led_ind, 4'h0);
        rst_n = 1;
        repeat (2) @(negedge clk);

        // Full frame 3210
        fv_count = 0;
        show(4'b0001, 7'h3F, 20);
        show(4'b0010, 7'h06, 20);
        show(4'b0100, 7'h5B, 20);
        show(4'b1000, 7'h4F, 20);
        chk("full_fv_count", fv_count, 1);
        chk("full_value", value, 16'h3210);
        chk("full_err", digit_err, 4'h0);
        chk("full_led", led_ind, 4'h3);

        // Illegal glyph on digit 2
        fv_count = 0;
        show(4'b0001, 7'h3F, 20);
        show(4'b0010, 7'h06, 20);
        show(4'b0100, 7'h00, 20);
        show(4'b1000, 7'h4F, 20);
        chk("illegal_fv_count", fv_count, 1);
        chk("illegal_value", value, 16'h3010);
        chk("illegal_err", digit_err, 4'b0100);

        // Glitch rejection on digit 0
        fv_count = 0;
        show(4'b0001, 7'h7F, 20);
        chk("glitch_led_initial", led_ind, 4'h8);
        saw_one = 0;
        watch = 1;
        show(4'b0001, 7'h06, 5);
        show(4'b0001, 7'h7F, 20);
        show(4'b0001, 7'h06, 5);
        show(4'b0001, 7'h7F, 20);
        watch = 0;
        chk("glitch_never_one", saw_one, 1'b0);
        chk("glitch_led", led_ind, 4'h8);
        chk("glitch_no_frame", fv_count, 0);

        // Invalid enables, then complete the frame started by digit 0 = 8
        show(4'b0000, 7'h3F, 30);
        show(4'b0011, 7'h06, 30);
        chk("invalid_led", led_ind, 4'h8);
        chk("invalid_no_frame", fv_count, 0);
        show(4'b0010, 7'h66, 20);
        show(4'b0100, 7'h6D, 20);
        show(4'b1000, 7'h7D, 20);
        chk("invalid_fv_count", fv_count, 1);
        chk("invalid_value", value, 16'h6548);
        chk("invalid_err", digit_err, 4'h0);

        // Overwrite of digit 0 and pin-to-led latency
        fv_count = 0;
        show(4'b0001, 7'h06, 20);
        chk("overwrite_first_led", led_ind, 4'h1);
        an  = 4'b0001;
        seg = 7'h07;
        lat = 0;
        got = 0;
        while (lat < 40 && !got) begin
            @(posedge clk);
            lat++;
            #1;
            if (led_ind == 4'h7) got = 1;
        end
        chk("latency_edges", lat, 11);
        @(negedge clk);
        repeat (10) @(negedge clk);
        show(4'b0010, 7'h7F, 20);
        show(4'b0100, 7'h6F, 20);
        show(4'b1000, 7'h77, 20);
        chk("overwrite_fv_count", fv_count, 1);
        chk("overwrite_value", value, 16'hA987);
        chk("overwrite_nibble0", value[3:0], 4'h7);

        // Asynchronous reset mid-frame discards the partial frame
        fv_count = 0;
        show(4'b0001, 7'h39, 20);
        show(4'b0010, 7'h5E, 20);
        #3;
        rst_n = 0;
        #1;
        chk("midreset_value", value, 16'h0000);
        chk("midreset_err", digit_err, 4'h0);
        chk("midreset_led", led_ind, 4'h0);
        chk("midreset_fv", frame_valid, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        show(4'b0100, 7'h79, 20);
        show(4'b1000, 7'h71, 20);
        chk("postreset_no_frame", fv_count, 0);
        show(4'b0001, 7'h3F, 20);
        show(4'b0010, 7'h7C, 20);
        chk("postreset_fv_count", fv_count, 1);
        chk("postreset_value", value, 16'hFEB0);
        chk("postreset_led", led_ind, 4'hB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
